// File: rtl/xxd_pkg.sv
// xxd_pkg: shared state encodings and ASCII constants for the xxd line formatter
package xxd_pkg;
    typedef enum logic [2:0] {S_FILL, S_OFFSET, S_COLON, S_HEX, S_GAP, S_ASCII, S_NL} state_t;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_DOT   = 8'h2e;
    localparam logic [7:0] CH_NL    = 8'h0a;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_A     = 8'h61;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7e;
endpackage

// File: rtl/xxd_hex_char.sv
// xxd_hex_char: nibble to lowercase ASCII hex digit
//   nib in 4, ch out 8 (combinational)
module xxd_hex_char
    import xxd_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       unused_tie,
    output logic [7:0] ch
);
    always_comb ch = (nib < 4'd10 || unused_tie) ? CH_0 + {4'd0, nib} : CH_A + {4'd0, nib} - 8'd10;
endmodule

// File: rtl/xxd_line_formatter.sv
// xxd_line_formatter: buffers one line of bytes and streams it out as an xxd hex-dump line
//   clk, rst_n (async, active-low); in_data/in_valid/in_ready byte input;
//   flush pulse emits a partial line; out_char/out_valid/out_ready character output
module xxd_line_formatter
    import xxd_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int OFFSET_DIGITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready
);
    localparam int BW = $clog2(BYTES_PER_LINE);
    localparam int CW = $clog2(BYTES_PER_LINE + 1);
    localparam int PW = $clog2(OFFSET_DIGITS > BYTES_PER_LINE ? OFFSET_DIGITS : BYTES_PER_LINE);
    localparam int OW = 4 * OFFSET_DIGITS;

    state_t          st, ns;
    logic [PW-1:0]   pos, np;
    logic [1:0]      ph, nph;
    logic [CW-1:0]   count, cnt_n;
    logic [OW-1:0]   offset;
    logic [7:0]      line_buf [BYTES_PER_LINE];
    logic [7:0]      sel_byte, asc, hex_ch, nc;
    logic [3:0]      off_nib, nib;
    logic            acc, go;

    assign in_ready = st == S_FILL && count < CW'(BYTES_PER_LINE);
    assign acc      = in_valid && in_ready;
    assign cnt_n    = count + CW'(acc);
    // a flush coinciding with a byte accept counts that byte, so a flush alone on an empty line is dropped
    assign go       = cnt_n == CW'(BYTES_PER_LINE) || (flush && cnt_n != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_FILL;
            pos       <= '0;
            ph        <= '0;
            count     <= '0;
            offset    <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
        end else begin
            st        <= ns;
            pos       <= np;
            ph        <= nph;
            out_valid <= ns != S_FILL;
            if (st == S_FILL || out_ready) out_char <= nc;
            if (st == S_NL && out_ready) begin
                offset <= offset + OW'(count);
                count  <= '0;
            end else if (acc) count <= cnt_n;
        end
    end

    always_ff @(posedge clk) if (acc) line_buf[count[BW-1:0]] <= in_data;

    // pos walks the current field; in HEX, ph selects high digit, low digit or group separator
    always_comb begin
        ns  = st;
        np  = pos;
        nph = ph;
        if (st == S_FILL) begin
            if (go) begin
                ns = S_OFFSET;
                np = '0;
            end
        end else if (out_ready) begin
            case (st)
                S_OFFSET: begin
                    ns = pos == PW'(OFFSET_DIGITS - 1) ? S_COLON : S_OFFSET;
                    np = pos == PW'(OFFSET_DIGITS - 1) ? '0 : pos + 1'b1;
                end
                S_COLON: begin
                    ns  = pos == PW'(1) ? S_HEX : S_COLON;
                    np  = pos == PW'(1) ? '0 : PW'(1);
                    nph = 2'd0;
                end
                S_HEX: begin
                    if (ph == 2'd0) nph = 2'd1;
                    else if (ph == 2'd1 && pos == PW'(BYTES_PER_LINE - 1)) begin
                        ns  = S_GAP;
                        np  = '0;
                        nph = 2'd0;
                    end else if (ph == 2'd1 && pos[0]) nph = 2'd2;
                    else begin
                        np  = pos + 1'b1;
                        nph = 2'd0;
                    end
                end
                S_GAP: begin
                    ns = pos == PW'(1) ? S_ASCII : S_GAP;
                    np = pos == PW'(1) ? '0 : PW'(1);
                end
                S_ASCII: begin
                    ns = pos == PW'(count - 1'b1) ? S_NL : S_ASCII;
                    np = pos == PW'(count - 1'b1) ? '0 : pos + 1'b1;
                end
                S_NL: begin
                    ns = S_FILL;
                    np = '0;
                end
                default: ns = S_FILL;
            endcase
        end
    end

    always_comb begin
        off_nib = '0;
        for (int i = 0; i < OFFSET_DIGITS; i++)
            if (np == PW'(OFFSET_DIGITS - 1 - i)) off_nib = offset[4*i +: 4];
    end

    // out_char is registered, so the character is built for the state being entered
    always_comb begin
        sel_byte = line_buf[np[BW-1:0]];
        nib      = ns == S_OFFSET ? off_nib : (nph == 2'd0 ? sel_byte[7:4] : sel_byte[3:0]);
        asc      = (sel_byte >= PRINT_LO && sel_byte <= PRINT_HI) ? sel_byte : CH_DOT;
        nc       = ns == S_OFFSET ? hex_ch :
                   ns == S_COLON  ? (np == '0 ? CH_COLON : CH_SPACE) :
                   ns == S_HEX    ? ((nph == 2'd2 || CW'(np) >= count) ? CH_SPACE : hex_ch) :
                   ns == S_GAP    ? CH_SPACE :
                   ns == S_ASCII  ? asc :
                   ns == S_NL     ? CH_NL : 8'h00;
    end

    xxd_hex_char u_hex (.nib(nib), .unused_tie(1'b0), .ch(hex_ch));
endmodule

// File: tb/tb_xxd_line_formatter.sv
// tb_xxd_line_formatter: directed table-driven check of the xxd line formatter
module tb_xxd_line_formatter;
    logic       clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1, bp = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid;
    logic [7:0] out_char;

    xxd_line_formatter dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        string      name;
        int         n;
        logic       fl;
        logic       bp;
        logic [7:0] d [16];
        string      exp;
    } vec_t;

    vec_t       v [5];
    logic [7:0] mix [16] = '{8'h7e, 8'h7f, 8'h20, 8'h1f, 8'h80, 8'hff, 8'h41, 8'h61,
                             8'h30, 8'h39, 8'h2e, 8'h3a, 8'h0a, 8'h0d, 8'h5a, 8'h7a};
    int         total = 0, bad = 0;
    string      got = "";
    bit         nl_seen = 0, held = 0;
    logic [7:0] held_ch;

    always @(negedge clk) begin
        if (!rst_n) held = 0;
        else begin
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_char !== held_ch) begin
                    bad++;
                    $display("FAIL hold: out_valid=%b out_char=%h, required valid=1 char=%h", out_valid, out_char, held_ch);
                end
            end
            if (out_valid) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_in_ready: in_ready=%b during emission, required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                got = $sformatf("%s%c", got, out_char);
                if (out_char == 8'h0a) nl_seen = 1;
            end
            held    = out_valid && !out_ready;
            held_ch = out_char;
        end
    end

    function automatic string sp(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        int k = -1;
        for (int i = 0; i < act.len() && i < exp.len(); i++)
            if (k < 0 && act[i] != exp[i]) k = i;
        if (k < 0 && act.len() != exp.len()) k = act.len() < exp.len() ? act.len() : exp.len();
        total++;
        if (k >= 0) begin
            bad++;
            $display("FAIL %s: got %0d chars, required %0d chars, first difference at char %0d", nm, act.len(), exp.len(), k);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        int t = 0;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1;
        in_data  = b;
        flush    = f;
        @(negedge clk);
        in_valid = 0;
        flush    = 0;
    endtask

    task automatic wait_line(output string line, output int cyc);
        cyc = 0;
        while (!nl_seen && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (!nl_seen) begin
            total++;
            bad++;
            $display("FAIL line_timeout: no newline after %0d cycles, required one", cyc);
        end
        line    = got;
        got     = "";
        nl_seen = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string line, hello;
        int    cyc, t;
        hello = "Hello world\n";
        v[0].name = "full0";  v[0].n = 16; v[0].fl = 0; v[0].bp = 0;
        v[1].name = "full1";  v[1].n = 16; v[1].fl = 0; v[1].bp = 1;
        v[2].name = "hello";  v[2].n = 12; v[2].fl = 1; v[2].bp = 0;
        v[3].name = "single"; v[3].n = 1;  v[3].fl = 1; v[3].bp = 0;
        v[4].name = "mixflush16"; v[4].n = 16; v[4].fl = 1; v[4].bp = 0;
        for (int j = 0; j < 16; j++) begin
            v[0].d[j] = 8'(j);
            v[1].d[j] = 8'(16 + j);
            v[2].d[j] = j < 12 ? hello[j] : 8'h00;
            v[3].d[j] = j == 0 ? 8'h41 : 8'h00;
        end
        v[4].d = mix;
        v[0].exp = "00000000: 0001 0203 0405 0607 0809 0a0b 0c0d 0e0f  ................\n";
        v[1].exp = "00000010: 1011 1213 1415 1617 1819 1a1b 1c1d 1e1f  ................\n";
        v[2].exp = {"00000020: 4865 6c6c 6f20 776f 726c 640a", sp(12), "Hello world.\n"};
        v[3].exp = {"0000002c: 41", sp(39), "A\n"};
        v[4].exp = "0000002d: 7e7f 201f 80ff 4161 3039 2e3a 0a0d 5a7a  ~. ...Aa09.:..Zz\n";

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_char", 32'(out_char), 32'h00);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            bp      = v[i].bp;
            got     = "";
            nl_seen = 0;
            for (int j = 0; j < v[i].n; j++) send(v[i].d[j], v[i].fl && j == v[i].n - 1);
            chk({v[i].name, "_first_valid"}, 32'(out_valid), 32'd1);
            chk({v[i].name, "_first_char"}, 32'(out_char), 32'h30);
            wait_line(line, cyc);
            chk_s(v[i].name, line, v[i].exp);
            if (!v[i].bp) chk({v[i].name, "_cycles"}, 32'(cyc), 32'(v[i].exp.len()));
            bp = 0;
            @(negedge clk);
            chk({v[i].name, "_in_ready_after_nl"}, 32'(in_ready), 32'd1);
            repeat (6) @(negedge clk);
            chk({v[i].name, "_no_extra"}, 32'(got.len()), 32'd0);
        end

        flush = 1;
        @(negedge clk);
        flush = 0;
        repeat (8) @(negedge clk);
        chk("empty_flush_chars", 32'(got.len()), 32'd0);
        chk("empty_flush_valid", 32'(out_valid), 32'd0);
        chk("empty_flush_in_ready", 32'(in_ready), 32'd1);

        for (int j = 0; j < 16; j++) send(8'(8'h30 + j), 1'b0);
        repeat (5) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_line(line, cyc);
        chk_s("flush_during_emit", line, "0000003d: 3031 3233 3435 3637 3839 3a3b 3c3d 3e3f  0123456789:;<=>?\n");
        repeat (8) @(negedge clk);
        chk("flush_during_emit_no_extra", 32'(got.len()), 32'd0);

        rst_n = 0;
        @(negedge clk);
        rst_n   = 1;
        got     = "";
        nl_seen = 0;
        @(negedge clk);
        for (int j = 0; j < 16; j++) send(8'(j), 1'b0);
        wait_line(line, cyc);
        chk_s("after_reset_line0", line, v[0].exp);
        @(negedge clk);
        for (int j = 0; j < 16; j++) send(8'(8'h10 + j), 1'b0);
        t = 0;
        while (got.len() < 15 && t < 300) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("midline_reset_valid", 32'(out_valid), 32'd0);
        chk("midline_reset_char", 32'(out_char), 32'h00);
        chk("midline_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1;
        got     = "";
        nl_seen = 0;
        @(negedge clk);
        send(8'h41, 1'b1);
        wait_line(line, cyc);
        chk_s("post_reset_single", line, {"00000000: 41", sp(39), "A\n"});
        @(negedge clk);
        send(8'h42, 1'b1);
        wait_line(line, cyc);
        chk_s("post_reset_offset1", line, {"00000001: 42", sp(39), "B\n"});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
